// File: rtl/regfile_dump_unit.sv
// Register-file dump engine: halts the core, then streams every register as (index, value) beats.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
`timescale 1ns/1ps
module regfile_dump_unit #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = 5,
  parameter int RUN_CYCLES = 10,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [1:0]        dbg_state_o
);

  // Stream handshake: a beat transfers on any rising edge where dump_valid & dump_ready;
  // once dump_valid is raised it stays high, with idx/data stable, until that transfer.

  typedef enum logic [1:0] {RUN, HALT, SEND, DONE} state_t;

  localparam bit                AUTO_EN  = (RUN_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TRIG_CNT = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hold_q, hold_d;
  logic               send;
  logic               fire;
  logic               beat_last;

`ifdef DUMP_CHECKSUM_EN
  logic               csum_q, csum_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               reg_last;

  assign reg_last  = !csum_q && (idx_q == LAST_IDX);
  assign beat_last = csum_q;
`else
  assign beat_last = (idx_q == LAST_IDX);
`endif

  assign send = (state_q == SEND);
  // A beat already offered keeps valid even if halt_ack drops before it transfers.
  assign dump_valid = send && (halt_ack || hold_q);
  assign fire       = dump_valid && dump_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d  = csum_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      RUN: begin
        if (start || (AUTO_EN && (cnt_q == TRIG_CNT))) state_d = HALT;
      end
      HALT: begin
        if (halt_ack) begin
          state_d = SEND;
          idx_d   = '0;
          hold_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = 1'b0;
          acc_d   = '0;
`endif
        end
      end
      SEND: begin
        if (fire) begin
          hold_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          if (!csum_q) acc_d = acc_q ^ rf_rdata;
          if (beat_last)     state_d = DONE;
          else if (reg_last) csum_d  = 1'b1;
          else               idx_d   = idx_q + IDX_W'(1);
`else
          if (beat_last) state_d = DONE;
          else           idx_d   = idx_q + IDX_W'(1);
`endif
        end else if (dump_valid) begin
          hold_d = 1'b1;
        end
      end
      DONE: begin
        if (start) state_d = HALT;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      csum_q <= csum_d;
      acc_q  <= acc_d;
    end
  end

  assign dump_idx  = send ? (csum_q ? {IDX_W{1'b1}} : idx_q) : '0;
  assign dump_data = send ? (csum_q ? acc_q : rf_rdata) : '0;
`else
  assign dump_idx  = send ? idx_q : '0;
  assign dump_data = send ? rf_rdata : '0;
`endif

  assign rf_raddr    = send ? idx_q : '0;
  assign dump_last   = dump_valid && beat_last;
  assign halt_req    = (state_q != RUN);
  assign done        = (state_q == DONE);
  assign cycle_cnt   = cnt_q;
  assign dbg_state_o = state_q;

endmodule
